// File: rtl/zero_mon_pkg.sv
// Shared defaults, types and helpers for the zero-run monitor.
package zero_mon_pkg;

  localparam int DEF_DATA_W     = 64;
  localparam int DEF_CHUNK_W    = 16;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_RUN_THRESH = 4;

  localparam int N_CHUNK = DEF_DATA_W / DEF_CHUNK_W;

  // Saturation value of the default-width run counter.
  localparam logic [DEF_CNT_W-1:0] CNT_SAT = '1;

  // Run tracker state is implied by the counter: zero means no run in progress.
  typedef enum logic {
    RUN_IDLE   = 1'b0,
    RUN_ACTIVE = 1'b1
  } run_state_e;

  function automatic int n_chunk(input int data_w, input int chunk_w);
    return data_w / chunk_w;
  endfunction

endpackage

// File: rtl/zero_run_monitor_if.sv
// Word stream in, zero flag and run report out.
interface zero_run_monitor_if #(
  parameter int DATA_W = zero_mon_pkg::DEF_DATA_W,
  parameter int CNT_W  = zero_mon_pkg::DEF_CNT_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              zf_valid;
  logic              zf;
  logic              rpt_valid;
  logic              rpt_ready;
  logic [CNT_W-1:0]  rpt_len;
  logic              rpt_sat;

  // Word source and report consumer side.
  modport master (
    output in_valid, in_data, in_last, rpt_ready,
    input  in_ready, zf_valid, zf, rpt_valid, rpt_len, rpt_sat
  );

  // Monitor side.
  modport slave (
    input  in_valid, in_data, in_last, rpt_ready,
    output in_ready, zf_valid, zf, rpt_valid, rpt_len, rpt_sat
  );
endinterface

// File: rtl/zero_chunk_reduce.sv
// Combinational per-chunk zero detection: one flag per CHUNK_W slice.
module zero_chunk_reduce #(
  parameter int DATA_W  = zero_mon_pkg::DEF_DATA_W,
  parameter int CHUNK_W = zero_mon_pkg::DEF_CHUNK_W,
  parameter int NC      = zero_mon_pkg::n_chunk(DATA_W, CHUNK_W)
) (
  input  logic [DATA_W-1:0] data,
  output logic [NC-1:0]     chunk_zero
);

  for (genvar gi = 0; gi < NC; gi++) begin : g_chunk
    assign chunk_zero[gi] = (data[gi*CHUNK_W +: CHUNK_W] == '0);
  end

endmodule

// File: rtl/zero_run_monitor.sv
// Two-stage zero detector with run-length tracking and a held run report.
module zero_run_monitor #(
  parameter int DATA_W     = zero_mon_pkg::DEF_DATA_W,
  parameter int CHUNK_W    = zero_mon_pkg::DEF_CHUNK_W,
  parameter int CNT_W      = zero_mon_pkg::DEF_CNT_W,
  parameter int RUN_THRESH = zero_mon_pkg::DEF_RUN_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  zero_run_monitor_if.slave bus
);
  import zero_mon_pkg::*;

  localparam int               NC      = n_chunk(DATA_W, CHUNK_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(RUN_THRESH);

  logic             en;
  logic             accept;
  run_state_e       run_state;
  logic [NC-1:0]    chunk_zero;

  logic             word_zero;
  logic             at_max;
  logic             run_end;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  logic             s1_valid_q, s1_valid_d;
  logic [NC-1:0]    s1_cz_q, s1_cz_d;
  logic             s1_last_q, s1_last_d;
  logic             zf_valid_q, zf_valid_d;
  logic             zf_q, zf_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             sat_flag_q, sat_flag_d;
  logic             rpt_valid_q, rpt_valid_d;
  logic [CNT_W-1:0] rpt_len_q, rpt_len_d;
  logic             rpt_sat_q, rpt_sat_d;

  zero_chunk_reduce #(
    .DATA_W  (DATA_W),
    .CHUNK_W (CHUNK_W),
    .NC      (NC)
  ) u_reduce (
    .data       (bus.in_data),
    .chunk_zero (chunk_zero)
  );

  // State register: pipeline, run tracker and report, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_cz_q     <= '0;
      s1_last_q   <= 1'b0;
      zf_valid_q  <= 1'b0;
      zf_q        <= 1'b0;
      run_cnt_q   <= '0;
      sat_flag_q  <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_len_q   <= '0;
      rpt_sat_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cz_q     <= s1_cz_d;
      s1_last_q   <= s1_last_d;
      zf_valid_q  <= zf_valid_d;
      zf_q        <= zf_d;
      run_cnt_q   <= run_cnt_d;
      sat_flag_q  <= sat_flag_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_len_q   <= rpt_len_d;
      rpt_sat_q   <= rpt_sat_d;
    end
  end

  // Next state: advance the pipeline and run tracker only while not stalled.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_cz_d     = s1_cz_q;
    s1_last_d   = s1_last_q;
    zf_valid_d  = zf_valid_q;
    zf_d        = zf_q;
    run_cnt_d   = run_cnt_q;
    sat_flag_d  = sat_flag_q;
    rpt_valid_d = rpt_valid_q;
    rpt_len_d   = rpt_len_q;
    rpt_sat_d   = rpt_sat_q;

    word_zero = &s1_cz_q;
    at_max    = (run_cnt_q == CNT_MAX);
    run_end   = !word_zero || s1_last_q;
    sat_nxt   = sat_flag_q || (word_zero && at_max);

    unique case (run_state)
      RUN_IDLE:   cnt_nxt = word_zero ? CNT_W'(1) : '0;
      default:    cnt_nxt = !word_zero ? run_cnt_q :
                            (at_max ? CNT_MAX : run_cnt_q + CNT_W'(1));
    endcase

    if (en) begin
      s1_valid_d  = accept;
      s1_cz_d     = chunk_zero;
      s1_last_d   = bus.in_last;
      zf_valid_d  = s1_valid_q;
      zf_d        = s1_valid_q && word_zero;
      // A consumed (or never-present) report drops unless replaced below.
      rpt_valid_d = 1'b0;

      if (s1_valid_q) begin
        if (run_end) begin
          if (cnt_nxt >= THRESH) begin
            rpt_valid_d = 1'b1;
            rpt_len_d   = cnt_nxt;
            rpt_sat_d   = sat_nxt;
          end
          run_cnt_d  = '0;
          sat_flag_d = 1'b0;
        end else begin
          run_cnt_d  = cnt_nxt;
          sat_flag_d = sat_nxt;
        end
      end
    end else begin
      // zf_valid is a pulse: a frozen stage must not re-present the same flag.
      zf_valid_d = 1'b0;
    end
  end

  // Outputs: stall whenever a report is waiting on the consumer.
  always_comb begin
    en            = !(rpt_valid_q && !bus.rpt_ready);
    accept        = bus.in_valid && en && !rst;
    run_state     = (run_cnt_q == '0) ? RUN_IDLE : RUN_ACTIVE;
    bus.in_ready  = en && !rst;
    bus.zf_valid  = zf_valid_q;
    bus.zf        = zf_q;
    bus.rpt_valid = rpt_valid_q;
    bus.rpt_len   = rpt_len_q;
    bus.rpt_sat   = rpt_sat_q;
  end

endmodule
